// File: rtl/bus_arbiter_responder.sv
// Two-cache bus arbiter plus memory responder model.
// Latency: grant visible the cycle after the request is sampled; RD reply starts MEM_LAT cycles after the grant window ends.
// Backpressure: the bus is held atomically; non-owner requests are not queued and must be held until re-sampled in IDLE.
//
// Ports:
//   plusclk, rst                        clock, synchronous active-high reset
//   bus_req_N / bus_req_op_N / clc_N    request, op (0 RD, 1 WR), requested grant cycles
//   bus_get_N                           grant window for cache N
//   get_reply_N                         memory reply valid for cache N
//   bus_busy, owner, st                 status: non-idle flag, current/last owner, state
module bus_arbiter_responder #(
  parameter int unsigned MEM_LAT   = 3,
  parameter int unsigned REPLY_CYC = 2,
  parameter int unsigned CLC_W     = 4
) (
  input  logic             plusclk,
  input  logic             rst,
  input  logic             bus_req_1,
  input  logic             bus_req_op_1,
  input  logic [CLC_W-1:0] bus_req_clc_1,
  input  logic             bus_req_2,
  input  logic             bus_req_op_2,
  input  logic [CLC_W-1:0] bus_req_clc_2,
  output logic             bus_get_1,
  output logic             bus_get_2,
  output logic             get_reply_1,
  output logic             get_reply_2,
  output logic             bus_busy,
  output logic             owner,
  output logic [1:0]       st
);

  // Counter must hold clc-1, MEM_LAT-1 and REPLY_CYC-1 (the latter two fit in 4 bits).
  localparam int unsigned CNT_W = (CLC_W > 4) ? CLC_W : 4;
  localparam logic [CNT_W-1:0] MEM_LOAD   = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] REPLY_LOAD = CNT_W'(REPLY_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_WAIT  = 2'd2,
    S_REPLY = 2'd3
  } state_t;

  state_t           state_q;
  logic             owner_q;
  logic             op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             bus_get_1_q;
  logic             bus_get_2_q;
  logic             get_reply_1_q;
  logic             get_reply_2_q;
  logic             bus_busy_q;

  // Arbitration: a lone requester wins; on a tie the non-owner wins.
  logic             req_any;
  logic             win;
  logic             win_op;
  logic [CLC_W-1:0] win_clc;
  logic [CNT_W-1:0] win_cnt;
  logic             owner_req;

  assign req_any   = bus_req_1 | bus_req_2;
  assign win       = (bus_req_1 & bus_req_2) ? ~owner_q : bus_req_2;
  assign win_op    = win ? bus_req_op_2 : bus_req_op_1;
  assign win_clc   = win ? bus_req_clc_2 : bus_req_clc_1;
  // A clc of 0 behaves like 1: load 0 so the first grant cycle is also the last.
  assign win_cnt   = (win_clc == '0) ? '0 : (CNT_W'(win_clc) - CNT_W'(1));
  assign owner_req = owner_q ? bus_req_2 : bus_req_1;

  always_ff @(posedge plusclk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      owner_q       <= 1'b1;
      op_q          <= 1'b0;
      cnt_q         <= '0;
      bus_get_1_q   <= 1'b0;
      bus_get_2_q   <= 1'b0;
      get_reply_1_q <= 1'b0;
      get_reply_2_q <= 1'b0;
      bus_busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_any) begin
            state_q     <= S_GRANT;
            owner_q     <= win;
            op_q        <= win_op;
            cnt_q       <= win_cnt;
            bus_get_1_q <= ~win;
            bus_get_2_q <= win;
            bus_busy_q  <= 1'b1;
          end
        end
        S_GRANT: begin
          if (!owner_req) begin
            // Owner withdrew: abandon the transaction, no reply.
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bus_get_1_q <= 1'b0;
            bus_get_2_q <= 1'b0;
            bus_busy_q  <= 1'b0;
          end else if (cnt_q == '0) begin
            bus_get_1_q <= 1'b0;
            bus_get_2_q <= 1'b0;
            if (op_q) begin
              state_q    <= S_IDLE;
              bus_busy_q <= 1'b0;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= MEM_LOAD;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_q       <= S_REPLY;
            cnt_q         <= REPLY_LOAD;
            get_reply_1_q <= ~owner_q;
            get_reply_2_q <= owner_q;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_REPLY: begin
          if (cnt_q == '0) begin
            state_q       <= S_IDLE;
            get_reply_1_q <= 1'b0;
            get_reply_2_q <= 1'b0;
            bus_busy_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus_get_1   = bus_get_1_q;
  assign bus_get_2   = bus_get_2_q;
  assign get_reply_1 = get_reply_1_q;
  assign get_reply_2 = get_reply_2_q;
  assign bus_busy    = bus_busy_q;
  assign owner       = owner_q;
  assign st          = state_q;

endmodule

// File: tb/tb_bus_arbiter_responder.sv
// Bench for bus_arbiter_responder: directed transactions, a schedule-queue reference model
// compared every cycle, and hand-computed literal checks per scenario.
module tb_bus_arbiter_responder;

  localparam int unsigned MEM_LAT   = 3;
  localparam int unsigned REPLY_CYC = 2;
  localparam int unsigned CLC_W     = 4;

  logic             plusclk;
  logic             rst;
  logic             bus_req_1, bus_req_op_1;
  logic [CLC_W-1:0] bus_req_clc_1;
  logic             bus_req_2, bus_req_op_2;
  logic [CLC_W-1:0] bus_req_clc_2;
  logic             bus_get_1, bus_get_2, get_reply_1, get_reply_2, bus_busy, owner;
  logic [1:0]       st;

  bus_arbiter_responder #(
    .MEM_LAT(MEM_LAT), .REPLY_CYC(REPLY_CYC), .CLC_W(CLC_W)
  ) dut (
    .plusclk(plusclk), .rst(rst),
    .bus_req_1(bus_req_1), .bus_req_op_1(bus_req_op_1), .bus_req_clc_1(bus_req_clc_1),
    .bus_req_2(bus_req_2), .bus_req_op_2(bus_req_op_2), .bus_req_clc_2(bus_req_clc_2),
    .bus_get_1(bus_get_1), .bus_get_2(bus_get_2),
    .get_reply_1(get_reply_1), .get_reply_2(get_reply_2),
    .bus_busy(bus_busy), .owner(owner), .st(st)
  );

  initial plusclk = 1'b0;
  always #5 plusclk = ~plusclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: on a grant, the whole expected output sequence of the
  // transaction is laid out in a queue; one entry is consumed per cycle.
  typedef struct packed {
    bit       g1, g2, r1, r2, busy, own;
    bit [1:0] st;
  } exp_t;

  function automatic exp_t mk(bit g1, bit g2, bit r1, bit r2, bit busy, bit own, bit [1:0] s);
    exp_t e;
    e.g1 = g1; e.g2 = g2; e.r1 = r1; e.r2 = r2; e.busy = busy; e.own = own; e.st = s;
    return e;
  endfunction

  exp_t sched[$];
  exp_t cur = '0;
  bit   owner_m = 1'b1;

  always @(posedge plusclk) begin
    bit w, op;
    int n;
    if (rst) begin
      sched.delete();
      owner_m = 1'b1;
      cur = mk(0, 0, 0, 0, 0, 1'b1, 2'd0);
    end else if (cur.st == 2'd1 && !(owner_m ? bus_req_2 : bus_req_1)) begin
      sched.delete();
      cur = mk(0, 0, 0, 0, 0, owner_m, 2'd0);
    end else if (sched.size() > 0) begin
      cur = sched.pop_front();
    end else if (cur.st == 2'd0 && (bus_req_1 || bus_req_2)) begin
      w  = (bus_req_1 && bus_req_2) ? !owner_m : bus_req_2;
      owner_m = w;
      op = w ? bus_req_op_2 : bus_req_op_1;
      n  = int'(w ? bus_req_clc_2 : bus_req_clc_1);
      if (n == 0) n = 1;
      for (int i = 0; i < n; i++) sched.push_back(mk(!w, w, 0, 0, 1, w, 2'd1));
      if (!op) begin
        for (int i = 0; i < MEM_LAT; i++) sched.push_back(mk(0, 0, 0, 0, 1, w, 2'd2));
        for (int i = 0; i < REPLY_CYC; i++) sched.push_back(mk(0, 0, !w, w, 1, w, 2'd3));
      end
      cur = sched.pop_front();
    end else begin
      cur = mk(0, 0, 0, 0, 0, owner_m, 2'd0);
    end
  end

  // Every-cycle comparison against the model plus exclusivity invariants.
  always @(negedge plusclk) begin
    logic [7:0] act;
    act = {bus_get_1, bus_get_2, get_reply_1, get_reply_2, bus_busy, owner, st};
    chk("model", 32'(act), 32'(cur));
    chk("get_onehot", 32'(bus_get_1 & bus_get_2), 32'd0);
    chk("reply_onehot", 32'(get_reply_1 & get_reply_2), 32'd0);
    chk("get_vs_reply", 32'((bus_get_1 | bus_get_2) & (get_reply_1 | get_reply_2)), 32'd0);
  end

  int n_g1, n_g2, n_r1, n_r2;

  task automatic clr();
    n_g1 = 0; n_g2 = 0; n_r1 = 0; n_r2 = 0;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge plusclk);
      n_g1 += int'(bus_get_1);
      n_g2 += int'(bus_get_2);
      n_r1 += int'(get_reply_1);
      n_r2 += int'(get_reply_2);
    end
  endtask

  task automatic req1(input bit v, input bit op, input int clc);
    bus_req_1 = v; bus_req_op_1 = op; bus_req_clc_1 = CLC_W'(clc);
  endtask

  task automatic req2(input bit v, input bit op, input int clc);
    bus_req_2 = v; bus_req_op_2 = op; bus_req_clc_2 = CLC_W'(clc);
  endtask

  task automatic counts(input string tag, input int g1, input int g2, input int r1, input int r2);
    chk({tag, "_n_get1"}, 32'(n_g1), 32'(g1));
    chk({tag, "_n_get2"}, 32'(n_g2), 32'(g2));
    chk({tag, "_n_rep1"}, 32'(n_r1), 32'(r1));
    chk({tag, "_n_rep2"}, 32'(n_r2), 32'(r2));
  endtask

  initial begin
    rst = 1'b1;
    req1(0, 0, 0);
    req2(0, 0, 0);
    clr();
    run(2);
    rst = 1'b0;

    // Reset / idle.
    run(5);
    chk("reset_st", 32'(st), 32'd0);
    chk("reset_owner", 32'(owner), 32'd1);
    chk("reset_busy", 32'(bus_busy), 32'd0);
    chk("reset_outs", 32'({bus_get_1, bus_get_2, get_reply_1, get_reply_2}), 32'd0);

    // Cache 1 RD clc=2: get cycles 1-2, wait 3-5, reply 6-7, idle 8.
    clr();
    req1(1, 0, 2);
    run(1);
    chk("rd_c1_get", 32'({st, bus_get_1, owner}), 32'({2'd1, 1'b1, 1'b0}));
    run(3);
    chk("rd_c4_wait", 32'({st, bus_get_1, get_reply_1}), 32'({2'd2, 1'b0, 1'b0}));
    run(3);
    chk("rd_c7_reply", 32'({st, get_reply_1}), 32'({2'd3, 1'b1}));
    req1(0, 0, 0);
    run(1);
    chk("rd_c8_idle", 32'({st, bus_busy, get_reply_1}), 32'd0);
    run(1);
    counts("rd", 2, 0, 2, 0);

    // Cache 2 WR clc=4: four grant cycles, no reply.
    clr();
    req2(1, 1, 4);
    run(4);
    chk("wr_c4_get", 32'({st, bus_get_2, owner}), 32'({2'd1, 1'b1, 1'b1}));
    run(1);
    chk("wr_c5_idle", 32'({st, bus_get_2, bus_busy}), 32'd0);
    req2(0, 0, 0);
    run(2);
    counts("wr", 0, 4, 0, 0);

    // Simultaneous requests twice: cache 1 then cache 2, idle gap between.
    clr();
    req1(1, 1, 2);
    req2(1, 1, 2);
    run(1);
    chk("rr1_get1", 32'({bus_get_1, bus_get_2, owner}), 32'({1'b1, 1'b0, 1'b0}));
    run(2);
    chk("rr_gap", 32'({st, bus_get_1, bus_get_2}), 32'd0);
    run(1);
    chk("rr2_get2", 32'({bus_get_1, bus_get_2, owner}), 32'({1'b0, 1'b1, 1'b1}));
    run(2);
    req1(0, 0, 0);
    req2(0, 0, 0);
    run(2);
    counts("rr", 2, 2, 0, 0);

    // Cache 1 RD clc=3 aborted after the first grant cycle.
    clr();
    req1(1, 0, 3);
    run(1);
    chk("abort_c1_get", 32'(bus_get_1), 32'd1);
    req1(0, 0, 0);
    run(1);
    chk("abort_c2_idle", 32'({st, bus_get_1, bus_busy}), 32'd0);
    run(8);
    counts("abort", 1, 0, 0, 0);

    // Reset during WAIT_MEM, then a fresh tie goes to cache 1.
    clr();
    req1(1, 0, 1);
    run(1);
    chk("rstw_get1", 32'(bus_get_1), 32'd1);
    run(2);
    chk("rstw_wait", 32'(st), 32'd2);
    rst = 1'b1;
    req1(0, 0, 0);
    run(1);
    chk("rstw_st", 32'({st, owner, bus_busy}), 32'({2'd0, 1'b1, 1'b0}));
    rst = 1'b0;
    run(4);
    counts("rstw", 1, 0, 0, 0);
    req1(1, 1, 1);
    req2(1, 1, 1);
    run(1);
    chk("rstw_fresh", 32'({bus_get_1, bus_get_2, owner}), 32'({1'b1, 1'b0, 1'b0}));
    req1(0, 0, 0);
    req2(0, 0, 0);
    run(3);

    // clc=0 behaves as a single grant cycle.
    clr();
    req2(1, 1, 0);
    run(1);
    chk("clc0_get2", 32'(bus_get_2), 32'd1);
    run(1);
    chk("clc0_idle", 32'({st, bus_get_2}), 32'd0);
    req2(0, 0, 0);
    run(2);
    counts("clc0", 0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
